// File: rtl/alu_arb_ctrl.sv
// Round-robin arbiter and sequencer for the shared alu_32bit.
// Two requesters, registered ALU drive, registered response.
module alu_arb_ctrl #(
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [DWIDTH-1:0] req_op1_0,
    input  logic [DWIDTH-1:0] req_op1_1,
    input  logic [DWIDTH-1:0] req_op2_0,
    input  logic [DWIDTH-1:0] req_op2_1,
    input  logic [3:0]        req_opcode_0,
    input  logic [3:0]        req_opcode_1,
    output logic [DWIDTH-1:0] alu_op1,
    output logic [DWIDTH-1:0] alu_op2,
    output logic [2:0]        alu_opsel,
    output logic              alu_mode,
    input  logic [DWIDTH-1:0] alu_result,
    input  logic [3:0]        alu_flags,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DWIDTH-1:0] rsp_result,
    output logic [3:0]        rsp_flags,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [DWIDTH-1:0] op1_q;
    logic [DWIDTH-1:0] op2_q;
    logic [3:0]        opc_q;
    logic              gid_q;
    logic              last_grant;
    logic              grant_id;
    logic              accept;
    logic              illegal;

    // Winner selection: a lone requester wins, a tie goes to !last_grant.
    always_comb begin
        grant_id = 1'b0;
        unique case (1'b1)
            (req_valid == 2'b11):
                grant_id = ~last_grant;
            (req_valid == 2'b10):
                grant_id = 1'b1;
            default:
                grant_id = 1'b0;
        endcase
    end

    // Next state and the combinational request handshake.
    always_comb begin
        state_nx  = state;
        req_ready = 2'b00;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    req_ready = grant_id ? 2'b10 : 2'b01;
                    state_nx  = EXEC;
                end
            end
            EXEC: state_nx = RESP;
            RESP: begin
                if (rsp_ready[gid_q]) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign accept  = |req_ready;
    assign illegal = (opc_q == 4'h7) || (opc_q[3:1] == 3'b111);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Capture the winning request; these also drive the ALU and hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op1_q      <= '0;
            op2_q      <= '0;
            opc_q      <= '0;
            gid_q      <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            op1_q      <= grant_id ? req_op1_1 : req_op1_0;
            op2_q      <= grant_id ? req_op2_1 : req_op2_0;
            opc_q      <= grant_id ? req_opcode_1 : req_opcode_0;
            gid_q      <= grant_id;
            last_grant <= grant_id;
        end
    end

    // Capture the ALU outcome in EXEC; illegal opcodes report zeros.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_err    <= 1'b0;
        end else if (state == EXEC) begin
            if (illegal) begin
                rsp_result <= '0;
                rsp_flags  <= '0;
                rsp_err    <= 1'b1;
            end else begin
                rsp_result <= alu_result;
                rsp_flags  <= alu_flags;
                rsp_err    <= 1'b0;
            end
        end
    end

    assign alu_op1   = op1_q;
    assign alu_op2   = op2_q;
    assign alu_opsel = opc_q[2:0];
    assign alu_mode  = opc_q[3];

    assign rsp_valid = (state == RESP) ? (gid_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_arb_ctrl.sv
// Scoreboard bench for alu_arb_ctrl with a behavioural ALU stub.
// Inputs change 1ns after posedge; all observation is at negedge.
module tb_alu_arb_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_op1_0, req_op1_1, req_op2_0, req_op2_1;
    logic [3:0]  req_opcode_0, req_opcode_1;
    logic [31:0] alu_op1, alu_op2, alu_result;
    logic [2:0]  alu_opsel;
    logic        alu_mode;
    logic [3:0]  alu_flags;
    logic [1:0]  rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_err, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic        id;
        logic [31:0] res;
        logic [3:0]  flg;
        logic        err;
        int          acc;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    alu_arb_ctrl #(.DWIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op1_0(req_op1_0), .req_op1_1(req_op1_1),
        .req_op2_0(req_op2_0), .req_op2_1(req_op2_1),
        .req_opcode_0(req_opcode_0), .req_opcode_1(req_opcode_1),
        .alu_op1(alu_op1), .alu_op2(alu_op2),
        .alu_opsel(alu_opsel), .alu_mode(alu_mode),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .rsp_err(rsp_err), .busy(busy)
    );

    // ALU behaviour: returns {c, z, o, s, result}.
    function automatic logic [35:0] alu_ref(
        input logic [31:0] a, input logic [31:0] b,
        input logic [3:0] opc);
        logic [32:0] s;
        logic [31:0] x, y, r;
        logic cin, arith, c, o;
        x = a; y = b; cin = 1'b0; arith = 1'b1; r = '0;
        case (opc)
            4'h0: ;
            4'h1: begin y = '0; cin = 1'b1; end
            4'h2: y = '1;
            4'h3: begin y = ~b; cin = 1'b1; end
            4'h4: begin x = b; y = ~a; cin = 1'b1; end
            4'h5: y = ~b;
            4'h6: cin = 1'b1;
            default: arith = 1'b0;
        endcase
        s = {1'b0, x} + {1'b0, y} + {32'b0, cin};
        c = 1'b0; o = 1'b0;
        if (arith) begin
            r = s[31:0];
            c = s[32];
            o = (x[31] == y[31]) && (r[31] != x[31]);
        end else begin
            case (opc)
                4'h8: r = a & b;
                4'h9: r = a | b;
                4'hA: r = a ^ b;
                4'hB: r = ~a;
                4'hC: r = ~(a & b);
                4'hD: r = ~(a | b);
                default: return {4'hF, a ^ b ^ 32'h5A5A5A5A};
            endcase
        end
        return {c, (r == 32'h0), o, r[31], r};
    endfunction

    function automatic bit is_illegal(input logic [3:0] opc);
        return opc == 4'h7 || opc == 4'hE || opc == 4'hF;
    endfunction

    always_comb begin
        {alu_flags, alu_result} =
            alu_ref(alu_op1, alu_op2, {alu_mode, alu_opsel});
    end

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Request-side observer: arbitration model and scoreboard push.
    logic lg = 1'b1;
    always @(negedge clk) begin : obs
        logic w;
        logic [31:0] a, b;
        logic [3:0] opc;
        exp_t e;
        if (!rst_n) begin
            lg = 1'b1;
        end else if (req_ready != 2'b00) begin
            w = (req_valid == 2'b11) ? ~lg : ~req_valid[0];
            chk("grant", req_ready, w ? 2'b10 : 2'b01);
            chk("ready_no_valid", req_ready & ~req_valid, 0);
            chk("accept_overlap", sbq.size(), 0);
            a   = w ? req_op1_1 : req_op1_0;
            b   = w ? req_op2_1 : req_op2_0;
            opc = w ? req_opcode_1 : req_opcode_0;
            e.id  = w;
            e.err = is_illegal(opc);
            e.acc = cyc;
            if (e.err) begin
                e.res = '0;
                e.flg = '0;
            end else begin
                {e.flg, e.res} = alu_ref(a, b, opc);
            end
            lg = w;
            sbq.push_back(e);
        end
    end

    // Response-side monitor: routing, latency, stability, data.
    logic        hold_v = 1'b0;
    logic        prev_v = 1'b0;
    logic [1:0]  h_valid;
    logic [31:0] h_res;
    logic [3:0]  h_flg;
    logic        h_err;
    always @(negedge clk) begin : mon
        exp_t e;
        bit done;
        if (!rst_n) begin
            sbq.delete();
            hold_v = 1'b0;
            prev_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_valid", rsp_valid, h_valid);
                chk("hold_result", rsp_result, h_res);
                chk("hold_flags", rsp_flags, h_flg);
                chk("hold_err", rsp_err, h_err);
            end
            hold_v = 1'b0;
            done = 1'b0;
            if (rsp_valid != 2'b00) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_rsp", rsp_valid, 0);
                end else begin
                    e = sbq[0];
                    if (!prev_v) begin
                        chk("latency", cyc - e.acc, 2);
                    end
                    chk("route", rsp_valid, e.id ? 2'b10 : 2'b01);
                    if (rsp_ready[e.id]) begin
                        chk("result", rsp_result, e.res);
                        chk("flags", rsp_flags, e.flg);
                        chk("err", rsp_err, e.err);
                        void'(sbq.pop_front());
                        done = 1'b1;
                    end
                end
                if (!done) begin
                    hold_v  = 1'b1;
                    h_valid = rsp_valid;
                    h_res   = rsp_result;
                    h_flg   = rsp_flags;
                    h_err   = rsp_err;
                end
            end
            prev_v = (rsp_valid != 2'b00);
            if (busy && req_valid != 2'b00) begin
                chk("ready_while_busy", req_ready, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] opc);
        if (id == 0) begin
            req_op1_0 = a; req_op2_0 = b; req_opcode_0 = opc;
        end else begin
            req_op1_1 = a; req_op2_1 = b; req_opcode_1 = opc;
        end
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    // Issue one request and return just after its accepting edge.
    task automatic send(input int id, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] opc);
        bit ok;
        ok = 1'b0;
        set_req(id, a, b, opc);
        req_valid[id] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("req_timeout", id, 99);
        step();
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_rsp(input int id, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rsp_valid[id]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("rsp_timeout", id, 99);
    endtask

    task automatic check_reset();
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_flags", rsp_flags, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_alu_op1", alu_op1, 0);
        chk("rst_alu_op2", alu_op2, 0);
        chk("rst_alu_opsel", alu_opsel, 0);
        chk("rst_alu_mode", alu_mode, 0);
    endtask

    initial begin
        bit ok;
        logic [1:0] acc;
        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        set_req(0, 0, 0, 0);
        set_req(1, 0, 0, 0);
        repeat (3) step();
        @(negedge clk);
        check_reset();
        step();
        rst_n = 1'b1;
        step();

        send(0, 32'd1, 32'd2, 4'h0);
        wait_rsp(0, ok);
        if (ok) begin
            chk("add_result", rsp_result, 32'h3);
            chk("add_flags", rsp_flags, 4'b0000);
        end
        step();

        send(1, 32'hEEEEEEEE, 32'hEEEEEEEE, 4'h6);
        wait_rsp(1, ok);
        if (ok) begin
            chk("addinc_result", rsp_result, 32'hDDDDDDDD);
            chk("addinc_flags", rsp_flags, 4'b1001);
            chk("addinc_err", rsp_err, 0);
        end
        step();

        // A fresh reset makes requester 0 the first tie winner.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_req(0, 32'd5, 32'd5, 4'h3);
        set_req(1, $urandom, $urandom, 4'h8);
        req_valid = 2'b11;
        @(negedge clk);
        chk("tie_first", req_ready, 2'b01);
        wait_rsp(0, ok);
        if (ok) begin
            chk("sub_result", rsp_result, 0);
            chk("sub_z", rsp_flags[2], 1);
        end
        step();
        wait_rsp(1, ok);
        step();
        wait_rsp(0, ok);
        step();
        req_valid = 2'b00;
        step();

        send(0, $urandom, $urandom, 4'hE);
        wait_rsp(0, ok);
        if (ok) begin
            chk("ill_err", rsp_err, 1);
            chk("ill_result", rsp_result, 0);
            chk("ill_flags", rsp_flags, 0);
        end
        step();
        send(0, 32'h0F0F0F0F, 32'h00FF00FF, 4'h8);
        wait_rsp(0, ok);
        if (ok) begin
            chk("post_ill_err", rsp_err, 0);
            chk("post_ill_result", rsp_result, 32'h000F000F);
        end
        step();

        rsp_ready = 2'b00;
        send(0, 32'h12345678, 32'h11111111, 4'hA);
        wait_rsp(0, ok);
        step();
        set_req(1, 32'd9, 32'd4, 4'h3);
        req_valid[1] = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_rsp_valid", rsp_valid, 2'b01);
        end
        step();
        rsp_ready = 2'b11;
        @(negedge clk);
        chk("bp_done_ready", req_ready, 0);
        step();
        @(negedge clk);
        chk("bp_next_grant", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        wait_rsp(1, ok);
        if (ok) chk("bp_r1_result", rsp_result, 32'd5);
        step();

        send(0, $urandom, $urandom, 4'h0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check_reset();
        repeat (5) step();
        send(0, 32'd40, 32'd2, 4'h0);
        wait_rsp(0, ok);
        if (ok) chk("post_rst_result", rsp_result, 32'd42);
        step();

        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            acc = req_ready & req_valid;
            step();
            for (int i = 0; i < 2; i++) begin
                if (acc[i] || !req_valid[i] ||
                    $urandom_range(0, 7) == 0) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    set_req(i, rnd_word(), rnd_word(),
                            4'($urandom_range(0, 15)));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0) ?
                        2'b11 : 2'($urandom_range(0, 3));
        end

        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (10) @(negedge clk);
        chk("drain", sbq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arb_ctrl.md
# alu_arb_ctrl

Two-port arbiter and sequencer for the shared combinational `alu_32bit`. It accepts operation requests from two requesters over valid/ready handshakes and grants the ALU round-robin. It drives the ALU from registered operands, captures result and flags one cycle later, and returns them to the granted requester over a valid/ready response channel. It sits between the decode/issue logic of the 32-bit processor and the ALU instance.

## Interface
- `DWIDTH`, 32, operand/result width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  active-low reset, synchronous to `clk` (sampled only on the rising edge)
- `req_valid[1:0]`  in  2  request valid, bit i = requester i
- `req_ready[1:0]`  out  2  request accepted this cycle (one-hot or zero)
- `req_op1_0`, `req_op1_1`  in  DWIDTH  operand 1 per requester
- `req_op2_0`, `req_op2_1`  in  DWIDTH  operand 2 per requester
- `req_opcode_0`, `req_opcode_1`  in  4  {mode, opsel[2:0]}, ALU encoding
- `alu_op1`, `alu_op2`  out  DWIDTH  to ALU `op1`/`op2`
- `alu_opsel`  out  3  to ALU `opsel`
- `alu_mode`  out  1  to ALU `mode`
- `alu_result`  in  DWIDTH  from ALU `result`
- `alu_flags`  in  4  from ALU {c_flag, z_flag, o_flag, s_flag}
- `rsp_valid[1:0]`  out  2  response valid, bit i = requester i (one-hot or zero)
- `rsp_ready[1:0]`  in  2  response accepted by requester i
- `rsp_result`  out  DWIDTH  registered result
- `rsp_flags`  out  4  registered {c,z,o,s}
- `rsp_err`  out  1  illegal opcode
- `busy`  out  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any `req_valid`, grant one requester; assert its `req_ready` combinationally. On the clock edge, capture op1, op2, opcode, and grant id, then go to EXEC. If no request is valid, stay in IDLE.
- Arbitration is round-robin on a `last_grant` bit. If only one requester is valid, it wins. If both are valid, the requester != `last_grant` wins. `last_grant` updates on every accept. Reset value is 1, so requester 0 wins the first tie.
- Legal opcodes: 0x0–0x6 and 0x8–0xD. Opcodes 0x7, 0xE, and 0xF are illegal.
- EXEC: ALU outputs are driven from the captured registers. On the clock edge, capture `alu_result` → `rsp_result` and `alu_flags` → `rsp_flags`. For an illegal opcode, capture result = 0, flags = 0, `rsp_err` = 1. Always go to RESP.
- RESP: assert `rsp_valid[grant_id]`; outputs are held stable. When `rsp_ready[grant_id]` is high, the response is complete: go to IDLE. `rsp_ready` of the non-granted requester is ignored.
- `req_ready` is 0 in EXEC and RESP. No new request is accepted in the RESP completion cycle.
- ALU drive outside EXEC: ALU outputs hold the last captured values (no toggling). Only EXEC-cycle values are meaningful.
- The controller performs no arithmetic. Result and flag semantics belong to the ALU; the controller passes them through unmodified.

## Timing
- Reset values:
  - state = IDLE, `req_ready` = 0 (no valid during reset), `rsp_valid` = 0.
  - `rsp_result` = 0, `rsp_flags` = 0, `rsp_err` = 0, `busy` = 0.
  - `alu_op1` = `alu_op2` = 0, `alu_opsel` = 0, `alu_mode` = 0, `last_grant` = 1.
- Latency: accept at edge N → EXEC in cycle N+1 → `rsp_valid` high in cycle N+2.
- Minimum initiation interval is 3 cycles per operation (accept, exec, response with immediate `rsp_ready`).
- Backpressure: `rsp_valid` and the response data stay stable while `rsp_ready` is low, for any number of cycles.
- A requester may drop `req_valid` before it is granted. No transaction is recorded.
- Reset in any state: the in-flight transaction is discarded, no response is issued, and all outputs return to reset values at that edge.
- `req_ready` depends combinationally on `req_valid` and state only, never on `rsp_ready`.

## Test plan
- Single op, requester 0: op1 = 1, op2 = 2, opcode 0x0 (add). → `req_ready[0]` in cycle 0; `rsp_valid[0]` in cycle 2; result = 0x00000003, flags = 0000.
- Carry case, requester 1: op1 = op2 = 0xEEEEEEEE, opcode 0x6 (addinc). → result = 0xDDDDDDDD, c = 1, z = 0, s = 1 (o as reported by ALU); `rsp_err` = 0.
- Tie arbitration: both requesters hold valid continuously; requester 0 sends 0x3 (sub) with 5,5 and requester 1 sends 0x8 (land).
  - Grants alternate 0, 1, 0, … starting with 0.
  - Requester 0's sub response has result = 0, z = 1.
  - Each response is routed only to its own `rsp_valid` bit.
- Illegal opcode 0xE from requester 0 → `rsp_err` = 1, result = 0, flags = 0; the following legal request completes normally with `rsp_err` = 0.
- Backpressure: hold `rsp_ready` low for 5 cycles in RESP.
  - `rsp_valid` and `rsp_result` remain stable.
  - `req_ready` stays 0 while requester 1 is valid.
  - Requester 1 is granted in the cycle after the response completes.
- Reset mid-operation: deassert `rst_n` for one edge during EXEC → no `rsp_valid` ever appears for that op; all outputs are at reset values; the next request from requester 0 is served with 2-cycle latency.
